// File: rtl/field_pow_pkg.sv
// Shared types and constants for the field exponentiation controller.
//
// Contents:
//   pow_state_t - controller FSM state encoding
//   FIELD_ONE   - multiplicative identity of the field (the value 1)
//   idx_width   - width of a bit-index counter for an n-bit exponent
//
// The field width comes from the global `F_NBITS define. It defaults to 32
// when the build does not supply it.

`ifndef F_NBITS
`define F_NBITS 32
`endif

package field_pow_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SQR  = 2'd1,
        ST_MUL  = 2'd2
    } pow_state_t;

    localparam logic [`F_NBITS-1:0] FIELD_ONE = {{(`F_NBITS-1){1'b0}}, 1'b1};

    // A 1-bit exponent still needs a 1-bit index register.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/field_pow_msb_find.sv
// Combinational leading-one detector for the exponent.
//
// Ports:
//   val     in  E_NBITS  value to scan
//   msb_idx out IW       index of the highest set bit (0 when val is 0)
//   is_zero out 1        val has no bits set
//
// This block is only instantiated when FIELD_POW_EARLY_EXIT_EN is defined.

`ifndef F_NBITS
`define F_NBITS 32
`endif

module field_pow_msb_find
    import field_pow_pkg::*;
#(
    parameter int E_NBITS = 32,
    parameter int IW      = idx_width(E_NBITS)
) (
    input  logic [E_NBITS-1:0] val,
    output logic [IW-1:0]      msb_idx,
    output logic               is_zero
);

    // The scan runs from low to high, so the last set bit it sees wins.
    always_comb begin
        msb_idx = '0;
        for (int i = 0; i < E_NBITS; i++) begin
            if (val[i]) begin
                msb_idx = IW'(i);
            end
        end
    end

    assign is_zero = (val == '0);

endmodule

// File: rtl/field_pow_ctl.sv
// Field exponentiation controller: c = base^exp, computed left to right by
// square-and-multiply on an external field multiplier.
//
// Ports:
//   clk             in  1        rising-edge clock
//   rst             in  1        asynchronous, active-high reset
//   en              in  1        start strobe (taken only while ready=1)
//   base            in  F        field element, latched with en
//   exp             in  E_NBITS  unsigned exponent, latched with en
//   ready_pulse     out 1        one-cycle completion strobe
//   ready           out 1        idle; en is accepted
//   c               out F        result, held until the next completion
//   mul_en          out 1        one-cycle multiply request
//   mul_a, mul_b    out F        multiplier operands
//   mul_ready_pulse in  1        multiplier done (latency of 1 cycle or more)
//   mul_c           in  F        product, valid with mul_ready_pulse
//
// Configuration macro FIELD_POW_EARLY_EXIT_EN:
//   defined   - scanning starts at the highest set bit of exp. exp=0 completes
//               in the cycle after en and issues no multiplier operations.
//   undefined - scanning always starts at bit E_NBITS-1.
// Both builds produce the same results. Only latency and operation count
// differ between them.
//
// State table:
//   state   | meaning
//   ST_IDLE | waiting for en; ready=1
//   ST_SQR  | squaring acc for the current exponent bit
//   ST_MUL  | multiplying acc by the latched base (current bit is 1)

`ifndef F_NBITS
`define F_NBITS 32
`endif

module field_pow_ctl
    import field_pow_pkg::*;
#(
    parameter int E_NBITS = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [`F_NBITS-1:0] base,
    input  logic [E_NBITS-1:0]  exp,
    output logic                ready_pulse,
    output logic                ready,
    output logic [`F_NBITS-1:0] c,
    output logic                mul_en,
    output logic [`F_NBITS-1:0] mul_a,
    output logic [`F_NBITS-1:0] mul_b,
    input  logic                mul_ready_pulse,
    input  logic [`F_NBITS-1:0] mul_c
);

    localparam int            IW      = idx_width(E_NBITS);
    localparam logic [IW-1:0] TOP_IDX = IW'(E_NBITS - 1);

    pow_state_t          state, state_n;
    logic [IW-1:0]       bit_idx, bit_idx_n;
    logic [`F_NBITS-1:0] base_q, base_n;
    logic [E_NBITS-1:0]  exp_q, exp_n;
    logic [`F_NBITS-1:0] acc, acc_n;
    logic [`F_NBITS-1:0] c_n;
    logic                ready_pulse_n;
    logic                mul_en_n;
    logic [`F_NBITS-1:0] mul_a_n, mul_b_n;

    logic [IW-1:0]       start_idx;
    logic                exp_zero;
    logic                mul_done;
    logic                last_bit;

`ifdef FIELD_POW_EARLY_EXIT_EN
    field_pow_msb_find #(
        .E_NBITS (E_NBITS),
        .IW      (IW)
    ) u_msb_find (
        .val     (exp),
        .msb_idx (start_idx),
        .is_zero (exp_zero)
    );
`else
    assign start_idx = TOP_IDX;
    assign exp_zero  = 1'b0;
`endif

    // A product is taken only while an operation is outstanding and never in
    // the request cycle itself. This masks stray strobes, including one that
    // arrives late from an operation abandoned by reset.
    assign mul_done = (state != ST_IDLE) && !mul_en && mul_ready_pulse;
    assign last_bit = (bit_idx == '0);
    assign ready    = (state == ST_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            bit_idx     <= '0;
            base_q      <= '0;
            exp_q       <= '0;
            acc         <= FIELD_ONE;
            c           <= FIELD_ONE;
            ready_pulse <= 1'b0;
            mul_en      <= 1'b0;
            mul_a       <= '0;
            mul_b       <= '0;
        end else begin
            state       <= state_n;
            bit_idx     <= bit_idx_n;
            base_q      <= base_n;
            exp_q       <= exp_n;
            acc         <= acc_n;
            c           <= c_n;
            ready_pulse <= ready_pulse_n;
            mul_en      <= mul_en_n;
            mul_a       <= mul_a_n;
            mul_b       <= mul_b_n;
        end
    end

    // Operands are loaded on entry to SQR/MUL and then left untouched. They
    // therefore stay stable for the whole multiplier transaction. A new acc
    // coming from the multiplier is routed straight from mul_c, so the next
    // request does not wait a cycle for acc to update.
    always_comb begin
        state_n       = state;
        bit_idx_n     = bit_idx;
        base_n        = base_q;
        exp_n         = exp_q;
        acc_n         = acc;
        c_n           = c;
        ready_pulse_n = 1'b0;
        mul_en_n      = 1'b0;
        mul_a_n       = mul_a;
        mul_b_n       = mul_b;

        case (state)
            ST_IDLE: begin
                if (en) begin
                    base_n    = base;
                    exp_n     = exp;
                    acc_n     = FIELD_ONE;
                    bit_idx_n = start_idx;
                    if (exp_zero) begin
                        ready_pulse_n = 1'b1;
                        c_n           = FIELD_ONE;
                    end else begin
                        state_n  = ST_SQR;
                        mul_en_n = 1'b1;
                        mul_a_n  = FIELD_ONE;
                        mul_b_n  = FIELD_ONE;
                    end
                end
            end

            ST_SQR: begin
                if (mul_done) begin
                    acc_n = mul_c;
                    if (exp_q[bit_idx]) begin
                        state_n  = ST_MUL;
                        mul_en_n = 1'b1;
                        mul_a_n  = mul_c;
                        mul_b_n  = base_q;
                    end else if (!last_bit) begin
                        bit_idx_n = bit_idx - IW'(1);
                        mul_en_n  = 1'b1;
                        mul_a_n   = mul_c;
                        mul_b_n   = mul_c;
                    end else begin
                        state_n       = ST_IDLE;
                        ready_pulse_n = 1'b1;
                        c_n           = mul_c;
                    end
                end
            end

            ST_MUL: begin
                if (mul_done) begin
                    acc_n = mul_c;
                    if (!last_bit) begin
                        state_n   = ST_SQR;
                        bit_idx_n = bit_idx - IW'(1);
                        mul_en_n  = 1'b1;
                        mul_a_n   = mul_c;
                        mul_b_n   = mul_c;
                    end else begin
                        state_n       = ST_IDLE;
                        ready_pulse_n = 1'b1;
                        c_n           = mul_c;
                    end
                end
            end

            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_field_pow_ctl.sv
// Self-checking bench for field_pow_ctl with E_NBITS=8 and a 32-bit field.
// The multiplier model computes products modulo the prime 2^32-5. The
// expected results are powers computed by repeated multiplication.

`ifndef F_NBITS
`define F_NBITS 32
`endif

module tb_field_pow_ctl;

    localparam int          E_NBITS = 8;
    localparam int          FW      = `F_NBITS;
    localparam logic [63:0] PRIME   = 64'd4294967291;
`ifdef FIELD_POW_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               rst;
    logic               en;
    logic [FW-1:0]      base_in;
    logic [E_NBITS-1:0] exp_in;
    logic               ready_pulse;
    logic               ready;
    logic [FW-1:0]      c;
    logic               mul_en;
    logic [FW-1:0]      mul_a;
    logic [FW-1:0]      mul_b;
    logic               mul_ready_pulse;
    logic [FW-1:0]      mul_c;

    int checks  = 0;
    int errors  = 0;
    int n_mul   = 0;
    int n_pulse = 0;
    bit lat_rand = 1'b0;
    bit mul_busy = 1'b0;
    bit stale    = 1'b0;

    field_pow_ctl #(.E_NBITS(E_NBITS)) dut (
        .clk             (clk),
        .rst             (rst),
        .en              (en),
        .base            (base_in),
        .exp             (exp_in),
        .ready_pulse     (ready_pulse),
        .ready           (ready),
        .c               (c),
        .mul_en          (mul_en),
        .mul_a           (mul_a),
        .mul_b           (mul_b),
        .mul_ready_pulse (mul_ready_pulse),
        .mul_c           (mul_c)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    function automatic logic [63:0] pow_ref(input logic [63:0] b, input int e);
        logic [63:0] r;
        r = 64'd1;
        repeat (e) r = (r * (b % PRIME)) % PRIME;
        return r;
    endfunction

    // The early-exit build processes only the significant bits of exp.
    function automatic int ops_ref(input int e);
        if (EARLY) return $clog2(e + 1) + $countones(e);
        return E_NBITS + $countones(e);
    endfunction

    // Multiplier model. It samples on the falling edge and answers after
    // 'cnt' cycles. It checks that the operands hold still while it works.
    initial begin
        logic [FW-1:0] a_q, b_q;
        int cnt;
        a_q = '0;
        b_q = '0;
        cnt = 0;
        mul_ready_pulse = 1'b0;
        mul_c = '0;
        forever begin
            @(negedge clk);
            mul_ready_pulse = 1'b0;
            if (rst && mul_busy) stale = 1'b1;
            if (mul_busy) begin
                if (!stale) begin
                    chk("op_a_stable", mul_a, a_q);
                    chk("op_b_stable", mul_b, b_q);
                    chk("mul_en_while_busy", mul_en, 0);
                end
                cnt--;
                if (cnt == 0) begin
                    mul_ready_pulse = 1'b1;
                    mul_c = FW'((64'(a_q) * 64'(b_q)) % PRIME);
                    mul_busy = 1'b0;
                    stale = 1'b0;
                end
            end else if (mul_en === 1'b1) begin
                a_q = mul_a;
                b_q = mul_b;
                n_mul++;
                mul_busy = 1'b1;
                cnt = lat_rand ? int'($urandom_range(1, 6)) : 3;
            end
        end
    end

    always @(negedge clk) begin
        if (ready_pulse === 1'b1) n_pulse++;
    end

    task automatic wait_done(output bit done);
        done = 1'b0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            en = 1'b0;
            if (ready_pulse === 1'b1) begin
                done = 1'b1;
                break;
            end
        end
    endtask

    // Starts one operation, runs it to completion and checks the result, the
    // operation count and that exactly one strobe occurred. The task returns
    // just after the completion edge, so a following call issues en back to
    // back in the completion cycle.
    task automatic run_op(input logic [FW-1:0] b, input logic [E_NBITS-1:0] e, input string tag);
        int m0, p0;
        bit done;
        m0 = n_mul;
        p0 = n_pulse;
        chk({tag, "_ready_at_en"}, ready, 1);
        en = 1'b1;
        base_in = b;
        exp_in = e;
        @(negedge clk);
        en = 1'b0;
        if (EARLY && e == 0) chk({tag, "_pulse_next_cycle"}, ready_pulse, 1);
        else chk({tag, "_ready_low"}, ready, 0);
        if (ready_pulse === 1'b1) done = 1'b1;
        else wait_done(done);
        chk({tag, "_done"}, done, 1);
        #2;
        chk({tag, "_c"}, c, pow_ref(b, int'(e)));
        chk({tag, "_ops"}, n_mul - m0, ops_ref(int'(e)));
        chk({tag, "_pulses"}, n_pulse - p0, 1);
    endtask

    initial begin
        int m0, p0;
        bit done;
        logic [63:0] t;

        rst = 1'b1;
        en = 1'b0;
        base_in = '0;
        exp_in = '0;
        repeat (2) @(negedge clk);
        chk("rst_ready", ready, 1);
        chk("rst_ready_pulse", ready_pulse, 0);
        chk("rst_c", c, 1);
        chk("rst_mul_en", mul_en, 0);
        chk("rst_mul_a", mul_a, 0);
        chk("rst_mul_b", mul_b, 0);
        #2 rst = 1'b0;
        @(negedge clk);
        #2;

        run_op(3, 5, "p3_5");
        repeat (3) @(negedge clk);
        #2;
        run_op(7, 1, "p7_1");
        repeat (3) @(negedge clk);
        #2;
        run_op(9, 0, "p9_0");
        repeat (3) @(negedge clk);
        #2;

        // A second en while busy must be dropped entirely.
        m0 = n_mul;
        p0 = n_pulse;
        en = 1'b1;
        base_in = 3;
        exp_in = 5;
        @(negedge clk);
        en = 1'b0;
        repeat (3) @(negedge clk);
        chk("busy_ready_low", ready, 0);
        en = 1'b1;
        base_in = 2;
        exp_in = 3;
        wait_done(done);
        chk("busy_done", done, 1);
        #2;
        chk("busy_c", c, 243);
        repeat (60) @(negedge clk);
        #2;
        chk("busy_pulses", n_pulse - p0, 1);
        chk("busy_ops", n_mul - m0, ops_ref(5));

        // Reset in the middle of the first squaring.
        en = 1'b1;
        base_in = 5;
        exp_in = 200;
        @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_ready", ready, 1);
        chk("mid_rst_c", c, 1);
        chk("mid_rst_mul_en", mul_en, 0);
        chk("mid_rst_mul_a", mul_a, 0);
        chk("mid_rst_mul_b", mul_b, 0);
        @(negedge clk);
        #2 rst = 1'b0;
        m0 = n_mul;
        p0 = n_pulse;
        for (int i = 0; i < 20 && mul_busy; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        #2;
        chk("stale_idle", mul_busy, 0);
        chk("stale_pulses", n_pulse - p0, 0);
        chk("stale_ops", n_mul - m0, 0);
        chk("stale_c", c, 1);
        chk("stale_ready", ready, 1);
        run_op(2, 10, "p2_10");
        repeat (3) @(negedge clk);
        #2;

        // Random latency, with each en issued in the previous completion cycle.
        lat_rand = 1'b1;
        t = 64'($urandom);
        run_op(FW'(t % PRIME), 8'hFF, "rnd_ff");
        t = 64'($urandom);
        run_op(FW'(t % PRIME), 8'h00, "rnd_00");
        for (int k = 0; k < 8; k++) begin
            t = 64'($urandom);
            run_op(FW'(t % PRIME), E_NBITS'($urandom_range(0, 255)), "rnd");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog observed=running expected=finished");
        $fatal(1, "simulation time limit reached");
    end

endmodule
